// File: rtl/syzygy_adc_frame_align.sv
// Per-lane frame-alignment controller: rotates each lane's frame word until it matches
// FRAME_PATTERN, confirms lock and tracks loss of lock. SYZYGY_ADC_ALIGN_ERROR_EN builds align_error.
module syzygy_adc_frame_align #(
  parameter int unsigned           DATA_WIDTH    = 8,
  parameter int unsigned           NUM_LANES     = 2,
  parameter logic [DATA_WIDTH-1:0] FRAME_PATTERN = 8'hF0,
  parameter int unsigned           SLIP_WAIT     = 4,
  parameter int unsigned           LOCK_COUNT    = 16,
  parameter int unsigned           UNLOCK_COUNT  = 4
) (
  input  logic                                   slow_clk,
  input  logic                                   reset,
  input  logic                                   ena,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]        frame_data,
  output logic [NUM_LANES*$clog2(DATA_WIDTH)-1:0] bitslip_count,
  output logic [NUM_LANES-1:0]                   lane_locked,
  output logic [NUM_LANES-1:0]                   align_error,
  output logic                                   data_valid
);

  localparam int unsigned CW = $clog2(DATA_WIDTH);
  localparam int unsigned WW = $clog2(SLIP_WAIT + 2);
  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned UW = $clog2(UNLOCK_COUNT + 1);

  typedef enum logic [1:0] {StIdle, StWait, StCheck, StLocked} state_e;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    state_e                  state_q, state_d;
    logic [WW-1:0]           wait_q, wait_d;
    logic [MW-1:0]           match_q, match_d;
    logic [UW-1:0]           miss_q, miss_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    locked_q, locked_d;
    logic [DATA_WIDTH-1:0]   word;
    logic [2*DATA_WIDTH-1:0] dbl;
    logic                    match;
`ifdef SYZYGY_ADC_ALIGN_ERROR_EN
    localparam int unsigned SW = $clog2(2 * DATA_WIDTH + 1);
    logic [SW-1:0] slip_q, slip_d;
    logic          err_q, err_d;
`endif

    // Upper half of the shifted doubled word is the left rotation by count_q.
    assign word  = frame_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign dbl   = {word, word} << count_q;
    assign match = (dbl[2*DATA_WIDTH-1 -: DATA_WIDTH] == FRAME_PATTERN);

    always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      match_d  = match_q;
      miss_d   = miss_q;
      count_d  = count_q;
      locked_d = locked_q;
`ifdef SYZYGY_ADC_ALIGN_ERROR_EN
      slip_d   = slip_q;
      err_d    = err_q;
`endif
      if (!ena) begin
        // count_q is deliberately kept so a re-enable relocks without slipping.
        state_d  = StIdle;
        wait_d   = '0;
        match_d  = '0;
        miss_d   = '0;
        locked_d = 1'b0;
`ifdef SYZYGY_ADC_ALIGN_ERROR_EN
        slip_d   = '0;
        err_d    = 1'b0;
`endif
      end else begin
        unique case (state_q)
          StIdle: begin
            state_d = StWait;
            wait_d  = '0;
          end
          StWait: begin
            if (32'(wait_q) + 32'd1 >= SLIP_WAIT) state_d = StCheck;
            else wait_d = wait_q + 1'b1;
          end
          StCheck: begin
            if (match) begin
              if (32'(match_q) + 32'd1 >= LOCK_COUNT) begin
                state_d  = StLocked;
                locked_d = 1'b1;
                match_d  = '0;
`ifdef SYZYGY_ADC_ALIGN_ERROR_EN
                slip_d   = '0;
`endif
              end else begin
                match_d = match_q + 1'b1;
              end
            end else begin
              match_d = '0;
              count_d = (count_q == CW'(DATA_WIDTH - 1)) ? '0 : count_q + 1'b1;
              wait_d  = '0;
              state_d = StWait;
`ifdef SYZYGY_ADC_ALIGN_ERROR_EN
              if (32'(slip_q) < 2 * DATA_WIDTH) slip_d = slip_q + 1'b1;
              if (32'(slip_q) + 32'd1 >= 2 * DATA_WIDTH) err_d = 1'b1;
`endif
            end
          end
          StLocked: begin
            if (match) begin
              miss_d = '0;
            end else if (32'(miss_q) + 32'd1 >= UNLOCK_COUNT) begin
              state_d  = StCheck;
              locked_d = 1'b0;
              miss_d   = '0;
              match_d  = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        endcase
      end
    end

    always_ff @(posedge slow_clk) begin
      if (reset) begin
        state_q  <= StIdle;
        wait_q   <= '0;
        match_q  <= '0;
        miss_q   <= '0;
        count_q  <= '0;
        locked_q <= 1'b0;
`ifdef SYZYGY_ADC_ALIGN_ERROR_EN
        slip_q   <= '0;
        err_q    <= 1'b0;
`endif
      end else begin
        state_q  <= state_d;
        wait_q   <= wait_d;
        match_q  <= match_d;
        miss_q   <= miss_d;
        count_q  <= count_d;
        locked_q <= locked_d;
`ifdef SYZYGY_ADC_ALIGN_ERROR_EN
        slip_q   <= slip_d;
        err_q    <= err_d;
`endif
      end
    end

    assign bitslip_count[g*CW +: CW] = count_q;
    assign lane_locked[g]            = locked_q;
`ifdef SYZYGY_ADC_ALIGN_ERROR_EN
    assign align_error[g]            = err_q;
`else
    assign align_error[g]            = 1'b0;
`endif
  end

  logic data_valid_q, data_valid_d;

  // Gated by ena so data_valid drops together with lane_locked on disable.
  always_comb data_valid_d = ena & (&lane_locked);

  always_ff @(posedge slow_clk) begin
    if (reset) data_valid_q <= 1'b0;
    else       data_valid_q <= data_valid_d;
  end

  assign data_valid = data_valid_q;

endmodule
